mem_fill_arbiter: RTL and testbench

- Shares the single-ported multi-cycle main memory between the I-cache miss path (IF stage) and the D-cache miss and write-through store path (MEM stage).
- Grants one requester at a time and sequences an 8-word block fill: it issues the reads, counts returned words and steers each word into the owning cache's data array.
- Signals completion so the owning cache can write its tag and release its pipeline stall.
- Sits between the two caches and the memory model; it contains no storage for data.

---
 rtl/mem_fill_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Shares single-ported main memory between the I-cache miss path and the
// D-cache miss/write-through path, sequencing 8-word block fills into the owner.
module mem_fill_arbiter #(
  parameter int WORDS    = 8,
  parameter int OFF_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_miss,
  input  logic [15:0]                i_addr,
  input  logic                       d_miss,
  input  logic [15:0]                d_addr,
  input  logic                       d_wr,
  input  logic [15:0]                d_wdata,
  output logic                       d_wr_ack,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [15:0]                mem_addr,
  output logic [15:0]                mem_wdata,
  input  logic                       mem_valid,
  input  logic [15:0]                mem_rdata,
  output logic                       fill_i_we,
  output logic                       fill_d_we,
  output logic [$clog2(WORDS)-1:0]   fill_word,
  output logic [15:0]                fill_data,
  output logic                       i_done,
  output logic                       d_done,
  output logic                       busy
);

  localparam int               CNT_W     = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [15:0]      BASE_MASK = ~((16'd1 << OFF_BITS) - 16'd1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               owner_d_r;
  logic [15:0]        base_r;
  logic [CNT_W-1:0]   issue_cnt_r;
  logic               issue_done_r;
  logic [CNT_W-1:0]   rx_cnt_r;
  logic               grant_s;
  logic               grant_d_s;
  logic [15:0]        grant_base_s;
  logic [15:0]        issue_off_s;

  // Word address offset of the next read: two bytes per word.
  assign issue_off_s = {{(16-CNT_W-1){1'b0}}, issue_cnt_r, 1'b0};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant latch plus issue/receive counters; counters wrap to zero at block end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d_r    <= 1'b0;
      base_r       <= 16'h0000;
      issue_cnt_r  <= {CNT_W{1'b0}};
      issue_done_r <= 1'b0;
      rx_cnt_r     <= {CNT_W{1'b0}};
    end else if (grant_s) begin
      owner_d_r    <= grant_d_s;
      base_r       <= grant_base_s;
      issue_cnt_r  <= {CNT_W{1'b0}};
      issue_done_r <= 1'b0;
      rx_cnt_r     <= {CNT_W{1'b0}};
    end else if (state_r == ST_FILL) begin
      if (!issue_done_r) begin
        issue_cnt_r <= issue_cnt_r + CNT_ONE;
        if (issue_cnt_r == LAST_WORD) begin
          issue_done_r <= 1'b1;
        end
      end
      if (mem_valid) begin
        rx_cnt_r <= rx_cnt_r + CNT_ONE;
      end
    end
  end

  // Arbitration, next state and all outputs; everything is forced low during reset.
  always_comb begin
    state_nxt_s  = state_r;
    grant_s      = 1'b0;
    grant_d_s    = 1'b0;
    grant_base_s = 16'h0000;
    d_wr_ack     = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    fill_i_we    = 1'b0;
    fill_d_we    = 1'b0;
    fill_word    = {CNT_W{1'b0}};
    fill_data    = 16'h0000;
    i_done       = 1'b0;
    d_done       = 1'b0;
    busy         = 1'b0;
    if (rst) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // D side is older in the pipeline; a store never allocates.
          if (d_miss) begin
            grant_s      = 1'b1;
            grant_d_s    = 1'b1;
            grant_base_s = d_addr & BASE_MASK;
            state_nxt_s  = ST_FILL;
          end else if (d_wr) begin
            d_wr_ack  = 1'b1;
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
          end else if (i_miss) begin
            grant_s      = 1'b1;
            grant_base_s = i_addr & BASE_MASK;
            state_nxt_s  = ST_FILL;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_FILL: begin
          busy = 1'b1;
          if (!issue_done_r) begin
            mem_en   = 1'b1;
            mem_addr = base_r + issue_off_s;
          end else begin
            mem_en = 1'b0;
          end
          if (mem_valid) begin
            fill_word = rx_cnt_r;
            fill_data = mem_rdata;
            fill_i_we = ~owner_d_r;
            fill_d_we = owner_d_r;
            if (rx_cnt_r == LAST_WORD) begin
              i_done      = ~owner_d_r;
              d_done      = owner_d_r;
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_FILL;
            end
          end else begin
            fill_data = 16'h0000;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: table vectors, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_mem_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr, mem_valid;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        d_wr_ack, mem_en, mem_wr, fill_i_we, fill_d_we, i_done, d_done, busy;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0]  fill_word;

  always #5 clk = ~clk;

  mem_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
    .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .fill_i_we(fill_i_we), .fill_d_we(fill_d_we), .fill_word(fill_word), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: a busy flag plus queues of outstanding issue addresses / fill words
  bit          m_busy = 1'b0;
  bit          m_owner_d = 1'b0;
  logic [15:0] exp_issue[$];
  int          exp_fill[$];

  // memory model: in-order read returns after lat cycles
  typedef struct { logic [15:0] addr; int ready; } rd_t;
  rd_t mq[$];
  int  lat = 4;
  bit  rand_delay = 1'b0;

  int first_en, last_en, en_count, first_we, last_we, busy_fall;
  int last_i_done, last_d_done, last_ack;
  logic [15:0] last_en_addr;
  bit prev_busy = 1'b0;
  logic s_ack, s_en, s_wr;
  logic [15:0] s_addr, s_wdata;

  typedef struct {
    logic dm, dw, im;
    logic [15:0] da, dd, ia;
    logic e_ack, e_en, e_wr;
    logic [15:0] e_addr, e_wdata;
    logic e_busy;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [15:0] mem_func(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  function automatic logic [63:0] pack(input logic ack, en, wr, input logic [15:0] addr, wdata,
                                       input logic iwe, dwe, input logic [2:0] word,
                                       input logic [15:0] data, input logic idn, ddn, bsy);
    return {5'b0, ack, en, wr, addr, wdata, iwe, dwe, word, data, idn, ddn, bsy};
  endfunction

  function automatic logic [63:0] act_vec();
    return pack(d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, fill_i_we, fill_d_we,
                fill_word, fill_data, i_done, d_done, busy);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_marks();
    first_en = -1; last_en = -1; en_count = 0; first_we = -1; last_we = -1;
    busy_fall = -1; last_i_done = -1; last_d_done = -1; last_ack = -1;
  endtask

  // one clock cycle: drive memory returns, check outputs mid-cycle, advance model
  task automatic cycle();
    logic e_ack, e_en, e_wr, e_iwe, e_dwe, e_idn, e_ddn, e_bsy, fin, gnt, gnt_d;
    logic [15:0] e_addr, e_wdata, e_data, g_addr, a_addr, a_wdata, a_data;
    logic [2:0] e_word, a_word;
    bit sd_i, sd_d, sd_a;
    rd_t r;
    mem_valid = 1'b0;
    mem_rdata = 16'h0000;
    if (mq.size() > 0 && mq[0].ready <= cyc && (!rand_delay || $urandom_range(0, 3) != 0)) begin
      mem_valid = 1'b1;
      mem_rdata = mem_func(mq[0].addr);
      mq.delete(0);
    end
    @(negedge clk);
    e_ack = 0; e_en = 0; e_wr = 0; e_iwe = 0; e_dwe = 0; e_idn = 0; e_ddn = 0;
    e_addr = 0; e_wdata = 0; e_data = 0; e_word = 0; fin = 0; gnt = 0; gnt_d = 0; g_addr = 0;
    e_bsy = m_busy;
    if (!m_busy) begin
      if (d_miss) begin gnt = 1; gnt_d = 1; g_addr = d_addr; end
      else if (d_wr) begin
        e_ack = 1; e_en = 1; e_wr = 1; e_addr = d_addr; e_wdata = d_wdata;
      end
      else if (i_miss) begin gnt = 1; g_addr = i_addr; end
    end else begin
      if (exp_issue.size() > 0) begin e_en = 1; e_addr = exp_issue[0]; end
      if (mem_valid && exp_fill.size() > 0) begin
        e_iwe = !m_owner_d; e_dwe = m_owner_d;
        e_word = 3'(exp_fill[0]); e_data = mem_rdata;
        fin = (exp_fill.size() == 1);
        e_idn = fin && !m_owner_d; e_ddn = fin && m_owner_d;
      end
    end
    a_addr  = e_en ? mem_addr : 16'h0000;
    a_wdata = e_wr ? mem_wdata : 16'h0000;
    a_word  = (e_iwe | e_dwe) ? fill_word : 3'd0;
    a_data  = (e_iwe | e_dwe) ? fill_data : 16'h0000;
    check("cycle", pack(d_wr_ack, mem_en, mem_wr, a_addr, a_wdata, fill_i_we, fill_d_we,
                        a_word, a_data, i_done, d_done, busy),
          pack(e_ack, e_en, e_wr, e_addr, e_wdata, e_iwe, e_dwe, e_word, e_data, e_idn, e_ddn, e_bsy));
    if (m_busy) begin
      if (exp_issue.size() > 0) exp_issue.delete(0);
      if (mem_valid && exp_fill.size() > 0) begin
        exp_fill.delete(0);
        if (fin) m_busy = 0;
      end
    end
    if (gnt) begin
      m_busy = 1; m_owner_d = gnt_d;
      for (int k = 0; k < 8; k++) begin
        exp_issue.push_back((g_addr & 16'hFFF0) + 16'(2 * k));
        exp_fill.push_back(k);
      end
    end
    s_ack = d_wr_ack; s_en = mem_en; s_wr = mem_wr; s_addr = mem_addr; s_wdata = mem_wdata;
    if (mem_en) begin
      if (first_en < 0) first_en = cyc;
      last_en = cyc; en_count++; last_en_addr = mem_addr;
      if (!mem_wr) begin r.addr = mem_addr; r.ready = cyc + lat; mq.push_back(r); end
    end
    if (fill_i_we | fill_d_we) begin
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
    end
    if (i_done) last_i_done = cyc;
    if (d_done) last_d_done = cyc;
    if (d_wr_ack) last_ack = cyc;
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
    sd_i = i_done; sd_d = d_done; sd_a = d_wr_ack;
    @(posedge clk);
    #1;
    cyc++;
    if (sd_i) i_miss = 1'b0;
    if (sd_d) d_miss = 1'b0;
    if (sd_a) d_wr = 1'b0;
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((m_busy || i_miss || d_miss || d_wr) && n < max) begin
      cycle();
      n++;
    end
    check("idle_timeout", 64'({m_busy, i_miss, d_miss, d_wr}), 64'h0);
  endtask

  initial begin
    int t0;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h2002, 16'hBEEF, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h2002, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h7000, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h5004, 16'h55AA, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0};

    // reset: outputs low even with a store request and a stale memory return present
    rst = 1'b1; i_miss = 0; d_miss = 0; d_wr = 1; i_addr = 0; d_addr = 16'h1234; d_wdata = 16'h5678;
    mem_valid = 1'b1; mem_rdata = 16'hFFFF;
    clear_marks();
    #2;
    check("reset_outputs", act_vec(), 64'h0);
    @(negedge clk);
    check("reset_outputs2", act_vec(), 64'h0);
    d_wr = 0; mem_valid = 0; mem_rdata = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle();

    // I miss, latency 4: cycle-exact timeline
    i_miss = 1; i_addr = 16'h1236; clear_marks(); t0 = cyc;
    run_idle(40);
    cycle();
    check("t1_first_en", 64'(first_en), 64'(t0 + 1));
    check("t1_last_en", 64'(last_en), 64'(t0 + 8));
    check("t1_en_count", 64'(en_count), 64'd8);
    check("t1_first_we", 64'(first_we), 64'(t0 + 5));
    check("t1_last_we", 64'(last_we), 64'(t0 + 12));
    check("t1_i_done", 64'(last_i_done), 64'(t0 + 12));
    check("t1_busy_fall", 64'(busy_fall), 64'(t0 + 13));

    // simultaneous D and I miss: D first, I granted in IDLE cycle after d_done
    d_miss = 1; d_addr = 16'h4008; i_miss = 1; i_addr = 16'h0100; clear_marks();
    run_idle(60);
    check("t2_d_first", 64'(last_d_done >= 0 && last_d_done < last_i_done), 64'd1);
    check("t2_i_after_d", 64'(last_i_done - last_d_done), 64'd13);

    // store during an I fill is acked only in the IDLE cycle after i_done
    i_miss = 1; i_addr = 16'h0840; clear_marks();
    repeat (3) cycle();
    d_wr = 1; d_addr = 16'h3000; d_wdata = 16'h1234;
    run_idle(60);
    check("t4_ack_after_done", 64'(last_ack - last_i_done), 64'd1);

    // table-driven IDLE vectors
    for (int v = 0; v < 5; v++) begin
      d_miss = vecs[v].dm; d_wr = vecs[v].dw; i_miss = vecs[v].im;
      d_addr = vecs[v].da; d_wdata = vecs[v].dd; i_addr = vecs[v].ia;
      cycle();
      check($sformatf("vec%0d", v),
            64'({s_ack, s_en, s_wr, s_en ? s_addr : 16'h0000, s_wr ? s_wdata : 16'h0000, busy}),
            64'({vecs[v].e_ack, vecs[v].e_en, vecs[v].e_wr, vecs[v].e_addr, vecs[v].e_wdata, vecs[v].e_busy}));
      run_idle(80);
    end

    // reset in cycle 6 of a D fill, stale returns ignored, refill from word 0
    d_miss = 1; d_addr = 16'h6010; clear_marks();
    repeat (6) cycle();
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_zero", act_vec(), 64'h0);
    d_miss = 0;
    m_busy = 0; exp_issue.delete(); exp_fill.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    clear_marks();
    repeat (10) cycle();
    check("t5_no_stale_we", 64'(first_we), 64'(-1));
    check("t5_no_stale_done", 64'(last_d_done), 64'(-1));
    d_miss = 1; d_addr = 16'h6010; clear_marks();
    run_idle(40);
    check("t5_refill_done", 64'(last_d_done - first_en), 64'd11);

    // block at top of address space: no wrap into 0x0000
    i_miss = 1; i_addr = 16'hFFFA; clear_marks();
    run_idle(40);
    check("t6_last_addr", 64'(last_en_addr), 64'hFFFE);
    check("t6_en_count", 64'(en_count), 64'd8);

    // random traffic with variable latency and return gaps
    rand_delay = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      lat = int'($urandom_range(1, 6));
      if (!i_miss && $urandom_range(0, 7) == 0) begin
        i_miss = 1; i_addr = 16'($urandom);
      end
      if (!d_miss && !d_wr) begin
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
        if ($urandom_range(0, 9) == 0) d_miss = 1;
        else if ($urandom_range(0, 5) == 0) d_wr = 1;
      end else if (!d_miss && $urandom_range(0, 9) == 0) begin
        d_miss = 1;
      end
      cycle();
    end
    run_idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
